// File: rtl/ram_pkg.sv
// Shared constants and types for the dual-port frame RAM and its port-B burst reader.
package ram_pkg;

  localparam int ADDR_SIZE = 16;
  localparam int DATA_SIZE = 32;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [DATA_SIZE-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO; head is the oldest entry and is held stable until popped.
module stream_fifo2 #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_head,
  output logic [1:0]    o_count
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ram_burst_reader.sv
// Walks a contiguous RAM port-B address window and streams the words out through a
// 2-entry buffer that absorbs the RAM read latency and downstream backpressure.
module ram_burst_reader #(
  parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE,
  parameter int DATA_SIZE = ram_pkg::DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [ADDR_SIZE-1:0] length,
  output logic [ADDR_SIZE-1:0] addr_B,
  output logic                 r_e_B,
  input  logic [DATA_SIZE-1:0] data_out_B,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);
  import ram_pkg::*;

  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  rd_state_t              r_state;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [ADDR_SIZE-1:0]   r_remaining;
  logic [ADDR_SIZE-1:0]   r_addr_b;
  logic                   r_re;
  logic                   r_inflight;
  logic                   r_done;

  logic [1:0]             w_count;
  logic                   w_pop;
  logic [2:0]             w_outstanding;
  logic                   w_credit_ok;

  // Stream handshake: a word transfers on a rising edge where out_valid & out_ready;
  // while out_valid=1 and out_ready=0, out_data is held unchanged.
  assign w_pop = out_valid & out_ready;

  // Credit covers the buffer plus both latency stages: the read on the port this cycle
  // and the word on data_out_B waiting to be captured. A pop this edge frees one slot.
  assign w_outstanding = {1'b0, w_count} + {2'b00, r_re} + {2'b00, r_inflight};
  assign w_credit_ok   = (w_outstanding < (3'd2 + {2'b00, w_pop}));

  stream_fifo2 #(
    .DW (DATA_SIZE)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (data_out_B),
    .o_head  (out_data),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_addr_b    <= '0;
      r_re        <= 1'b0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_re       <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= r_re;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              // First read goes out on the accepting edge to shorten startup latency.
              r_re        <= 1'b1;
              r_addr_b    <= base_addr;
              r_addr      <= base_addr + ADDR_ONE;
              r_remaining <= length - ADDR_ONE;
              r_state     <= (length == ADDR_ONE) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (w_credit_ok) begin
            r_re        <= 1'b1;
            r_addr_b    <= r_addr;
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - ADDR_ONE;
            if (r_remaining == ADDR_ONE) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && (w_count == 2'd1) && !r_re && !r_inflight) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign addr_B    = r_addr_b;
  assign r_e_B     = r_re;
  assign out_valid = (w_count != 2'd0);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: behavioural port-B RAM, queue-based expectations per burst.
module tb_ram_burst_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] length = 16'd0;
  logic [15:0] addr_B;
  logic        r_e_B;
  logic [31:0] data_out_B = 32'd0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  logic [31:0] ram_mem [0:65535];
  int n_tests = 0;
  int n_fail  = 0;

  // clock/reset block
  always #5 clk = ~clk;

  // RAM port B: registered read, data one cycle after r_e_B
  always @(posedge clk) begin
    if (r_e_B) data_out_B <= ram_mem[addr_B];
  end

  ram_burst_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .addr_B     (addr_B),
    .r_e_B      (r_e_B),
    .data_out_B (data_out_B),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return 32'd245 + {16'd0, a};
  endfunction

  // One burst: reference is the list of addresses base..base+len-1 (mod 2^16) and their words.
  task automatic run_burst(input string name, input logic [15:0] base, input logic [15:0] len,
                           input int ready_pct, input int inject_cyc);
    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_q[$];
    int issued = 0, accepted = 0, done_cnt = 0, done_cyc = -1;
    int first_valid = -1, last_acc = -1, cyc = 0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic exp_busy;
    logic timed_out = 1'b1;
    for (int i = 0; i < int'(len); i++) begin
      exp_addr_q.push_back(base + 16'(i));
      exp_q.push_back(ram_word(base + 16'(i)));
    end
    start = 1'b1; base_addr = base; length = len;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 16'($urandom); length = 16'($urandom);
    while (cyc < 300) begin
      @(negedge clk);
      exp_busy = (len != 16'd0) && (done_cnt == 0) && !done;
      n_tests++;
      if (busy !== exp_busy) begin
        n_fail++; $display("FAIL %s/busy cyc %0d: got %b expected %b", name, cyc, busy, exp_busy);
      end
      n_tests++;
      if (issued - accepted > 2) begin
        n_fail++; $display("FAIL %s/credit cyc %0d: outstanding %0d expected <= 2", name, cyc, issued - accepted);
      end
      if (r_e_B) begin
        n_tests++;
        if (issued >= exp_addr_q.size()) begin
          n_fail++; $display("FAIL %s/extra_read: addr %h, expected no read", name, addr_B);
        end else if (addr_B !== exp_addr_q[issued]) begin
          n_fail++; $display("FAIL %s/addr #%0d: got %h expected %h", name, issued, addr_B, exp_addr_q[issued]);
        end
        issued++;
      end
      if (prev_hold) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_fail++; $display("FAIL %s/hold cyc %0d: got valid %b data %h expected 1 %h", name, cyc, out_valid, out_data, prev_data);
        end
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s/extra_word: got %h expected none", name, out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            n_fail++; $display("FAIL %s/data #%0d: got %h expected %h", name, accepted, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        accepted++;
        last_acc = cyc;
      end
      if (done) begin
        n_tests++;
        if ((len == 16'd0 && cyc != 0) || (len != 16'd0 && cyc != last_acc + 1)) begin
          n_fail++; $display("FAIL %s/done_timing: got cyc %0d expected %0d", name, cyc, (len == 16'd0) ? 0 : last_acc + 1);
        end
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_hold = out_valid & !out_ready;
      prev_data = out_data;
      if (done_cnt > 0 && cyc >= done_cyc + 3) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      out_ready = (ready_pct < 0) ? (cyc % 3 == 2) : (int'($urandom_range(0, 99)) < ready_pct);
      if (cyc == inject_cyc) begin
        start = 1'b1; base_addr = 16'h0200; length = 16'd7;
      end else begin
        start = 1'b0;
      end
      cyc++;
    end
    start = 1'b0;
    n_tests++;
    if (timed_out) begin
      n_fail++; $display("FAIL %s/timeout: no done within 300 cycles, accepted %0d of %0d", name, accepted, len);
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL %s/done_count: got %0d expected 1", name, done_cnt);
    end
    n_tests++;
    if (issued != int'(len) || accepted != int'(len)) begin
      n_fail++; $display("FAIL %s/counts: issued %0d accepted %0d expected %0d", name, issued, accepted, len);
    end
    n_tests++;
    if (first_valid != ((len == 16'd0) ? -1 : 2)) begin
      n_fail++; $display("FAIL %s/first_valid: got cyc %0d expected %0d", name, first_valid, (len == 16'd0) ? -1 : 2);
    end
    n_tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s/idle_after: got busy %b valid %b expected 0 0", name, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({addr_B, r_e_B, out_valid, busy, done} !== 20'd0 || out_data !== 32'd0) begin
      n_fail++; $display("FAIL reset: got addr %h re %b valid %b data %h busy %b done %b expected all 0",
                         addr_B, r_e_B, out_valid, out_data, busy, done);
    end
  endtask

  task automatic test_basic();
    run_burst("basic", 16'h0000, 16'd4, 100, -1);
  endtask

  task automatic test_backpressure();
    run_burst("backpressure", 16'h0000, 16'd4, -1, -1);
    run_burst("backpressure_long", 16'h0100, 16'd9, -1, -1);
  endtask

  task automatic test_zero_length();
    run_burst("zero_length", 16'h1234, 16'd0, 100, -1);
  endtask

  task automatic test_wrap();
    run_burst("wrap", 16'hFFFE, 16'd4, 100, -1);
    run_burst("wrap_bp", 16'hFFFD, 16'd6, 50, -1);
  endtask

  task automatic test_ignored_start();
    run_burst("ignored_start", 16'h0040, 16'd6, 100, 1);
    run_burst("ignored_start_bp", 16'h0080, 16'd5, 40, 3);
  endtask

  task automatic test_reset_mid_burst();
    int acc = 0, cyc = 0;
    logic [31:0] e;
    out_ready = 1'b1; start = 1'b1; base_addr = 16'h0000; length = 16'd8;
    @(posedge clk); #1 start = 1'b0;
    while (acc < 2 && cyc < 50) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = ram_word(16'(acc));
        n_tests++;
        if (out_data !== e) begin
          n_fail++; $display("FAIL reset_mid/data #%0d: got %h expected %h", acc, out_data, e);
        end
        acc++;
      end
      if (acc < 2) begin
        @(posedge clk); #1;
      end
      cyc++;
    end
    n_tests++;
    if (acc < 2) begin
      n_fail++; $display("FAIL reset_mid/timeout: accepted %0d expected 2", acc);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({addr_B, r_e_B, out_valid, busy, done} !== 20'd0 || out_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid/outputs: got addr %h re %b valid %b data %h busy %b done %b expected all 0",
                         addr_B, r_e_B, out_valid, out_data, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || out_valid !== 1'b0 || r_e_B !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid/quiet cyc %0d: got done %b valid %b re %b expected 0 0 0", i, done, out_valid, r_e_B);
      end
    end
    @(posedge clk); #1;
    run_burst("after_reset", 16'h0010, 16'd2, 100, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_burst($sformatf("random%0d", i), 16'($urandom), 16'($urandom_range(1, 24)),
                int'($urandom_range(20, 100)), -1);
    end
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_a", 16'h0300, 16'd3, 100, -1);
    run_burst("b2b_b", 16'h0303, 16'd1, 100, -1);
    run_burst("b2b_c", 16'h0304, 16'd0, 100, -1);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram_mem[a] = ram_word(16'(a));
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_wrap();
    test_ignored_start();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
